jtag_tap: RTL

JTAG_TAP -- requirements
Module: jtag_tap

---
 rtl/jtag_pkg.sv | 35 +++
 rtl/jtag_tap_fsm.sv | 75 +++++++
 rtl/jtag_tap.sv | 93 +++++++++
 3 files changed

// File: rtl/jtag_pkg.sv
// jtag_pkg: shared types and constants for the JTAG TAP controller.
//   IR_LEN       instruction register length
//   inst_t       instruction word type
//   IDCODE_INST  instruction selected in Test-Logic-Reset
//   BYPASS_INST  all-ones bypass instruction
//   tap_state_t  the 16 IEEE 1149.1 TAP controller states
package jtag_pkg;

    localparam int IR_LEN = 4;

    typedef logic [IR_LEN-1:0] inst_t;

    localparam inst_t IDCODE_INST = 4'b0010;
    localparam inst_t BYPASS_INST = 4'b1111;

    typedef enum logic [3:0] {
        S_TLR      = 4'd0,
        S_RTI      = 4'd1,
        S_SEL_DR   = 4'd2,
        S_CAP_DR   = 4'd3,
        S_SH_DR    = 4'd4,
        S_EX1_DR   = 4'd5,
        S_PAUSE_DR = 4'd6,
        S_EX2_DR   = 4'd7,
        S_UPD_DR   = 4'd8,
        S_SEL_IR   = 4'd9,
        S_CAP_IR   = 4'd10,
        S_SH_IR    = 4'd11,
        S_EX1_IR   = 4'd12,
        S_PAUSE_IR = 4'd13,
        S_EX2_IR   = 4'd14,
        S_UPD_IR   = 4'd15
    } tap_state_t;

endpackage

// File: rtl/jtag_tap_fsm.sv
// jtag_tap_fsm: TAP controller state register and strobe decode.
//   tck       test clock (state updates on rising edge)
//   trst      asynchronous active-high reset, forces Test-Logic-Reset
//   tms       test mode select
//   state     current TAP state
//   capdr     high in Capture-DR
//   shiftdr   high in Shift-DR
//   updatedr  high in Update-DR
//   tlr       high in Test-Logic-Reset
//
// state      | meaning
// -----------+-------------------------------------------
// S_TLR      | Test-Logic-Reset, IDCODE selected
// S_RTI      | Run-Test/Idle
// S_SEL_DR   | Select-DR-Scan
// S_CAP_DR   | Capture-DR, DR block loads parallel data
// S_SH_DR    | Shift-DR, DR shifts tdi -> dr_tdo
// S_EX1_DR   | Exit1-DR
// S_PAUSE_DR | Pause-DR, DR holds
// S_EX2_DR   | Exit2-DR
// S_UPD_DR   | Update-DR, DR block latches result
// S_SEL_IR   | Select-IR-Scan
// S_CAP_IR   | Capture-IR, IR loads IR_CAPTURE
// S_SH_IR    | Shift-IR
// S_EX1_IR   | Exit1-IR
// S_PAUSE_IR | Pause-IR, IR holds
// S_EX2_IR   | Exit2-IR
// S_UPD_IR   | Update-IR, curr_inst loads on falling edge
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       tck,
    input  logic       trst,
    input  logic       tms,
    output tap_state_t state,
    output logic       capdr,
    output logic       shiftdr,
    output logic       updatedr,
    output logic       tlr
);

    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            state <= S_TLR;
        end else begin
            case (state)
                S_TLR:      state <= tms ? S_TLR    : S_RTI;
                S_RTI:      state <= tms ? S_SEL_DR : S_RTI;
                S_SEL_DR:   state <= tms ? S_SEL_IR : S_CAP_DR;
                S_CAP_DR:   state <= tms ? S_EX1_DR : S_SH_DR;
                S_SH_DR:    state <= tms ? S_EX1_DR : S_SH_DR;
                S_EX1_DR:   state <= tms ? S_UPD_DR : S_PAUSE_DR;
                S_PAUSE_DR: state <= tms ? S_EX2_DR : S_PAUSE_DR;
                S_EX2_DR:   state <= tms ? S_UPD_DR : S_SH_DR;
                S_UPD_DR:   state <= tms ? S_SEL_DR : S_RTI;
                S_SEL_IR:   state <= tms ? S_TLR    : S_CAP_IR;
                S_CAP_IR:   state <= tms ? S_EX1_IR : S_SH_IR;
                S_SH_IR:    state <= tms ? S_EX1_IR : S_SH_IR;
                S_EX1_IR:   state <= tms ? S_UPD_IR : S_PAUSE_IR;
                S_PAUSE_IR: state <= tms ? S_EX2_IR : S_PAUSE_IR;
                S_EX2_IR:   state <= tms ? S_UPD_IR : S_SH_IR;
                S_UPD_IR:   state <= tms ? S_SEL_DR : S_RTI;
                default:    state <= S_TLR;
            endcase
        end
    end

    // Strobes decode the state register directly so the DR block sees
    // them in the same cycle the state is entered.
    assign capdr    = (state == S_CAP_DR);
    assign shiftdr  = (state == S_SH_DR);
    assign updatedr = (state == S_UPD_DR);
    assign tlr      = (state == S_TLR);

endmodule

// File: rtl/jtag_tap.sv
// jtag_tap: IEEE 1149.1 TAP controller with instruction register.
//   IR_CAPTURE  value loaded into the IR shift register in Capture-IR
//   tck         test clock, both edges used
//   trst        asynchronous active-high reset
//   tms         test mode select
//   tdi         serial data in
//   dr_tdo      serial out of the data-register block (negedge registered)
//   tdo         device serial out
//   tdo_oe      (JTAG_TAP_TDO_OE_EN only) high while shifting DR or IR
//   capdr/shiftdr/updatedr  DR strobes
//   curr_inst   active instruction
//   tlr         high in Test-Logic-Reset
// Optional feature macro: JTAG_TAP_TDO_OE_EN adds the tdo_oe output.
module jtag_tap
    import jtag_pkg::*;
#(
    parameter inst_t IR_CAPTURE = {{(IR_LEN-2){1'b0}}, 2'b01}
) (
    input  logic  tck,
    input  logic  trst,
    input  logic  tms,
    input  logic  tdi,
    input  logic  dr_tdo,
    output logic  tdo,
`ifdef JTAG_TAP_TDO_OE_EN
    output logic  tdo_oe,
`endif
    output logic  capdr,
    output logic  shiftdr,
    output logic  updatedr,
    output inst_t curr_inst,
    output logic  tlr
);

    tap_state_t state;
    inst_t      ir_sr;
    logic       tdo_ir;
    logic       tdo_sel;

    jtag_tap_fsm u_fsm (
        .tck      (tck),
        .trst     (trst),
        .tms      (tms),
        .state    (state),
        .capdr    (capdr),
        .shiftdr  (shiftdr),
        .updatedr (updatedr),
        .tlr      (tlr)
    );

    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            ir_sr <= IR_CAPTURE;
        end else if (state == S_CAP_IR) begin
            ir_sr <= IR_CAPTURE;
        end else if (state == S_SH_IR) begin
            ir_sr <= {tdi, ir_sr[IR_LEN-1:1]};
        end
    end

    // Falling-edge side: instruction update and tdo retiming, so tdo is
    // stable around the rising edge at which the next device samples it.
    always_ff @(negedge tck or posedge trst) begin
        if (trst) begin
            curr_inst <= IDCODE_INST;
            tdo_ir    <= 1'b0;
            tdo_sel   <= 1'b0;
        end else begin
            if (state == S_TLR) begin
                curr_inst <= IDCODE_INST;
            end else if (state == S_UPD_IR) begin
                curr_inst <= ir_sr;
            end
            if (state == S_SH_IR) begin
                tdo_ir <= ir_sr[0];
            end
            tdo_sel <= (state == S_SH_IR);
        end
    end

    assign tdo = tdo_sel ? tdo_ir : dr_tdo;

`ifdef JTAG_TAP_TDO_OE_EN
    always_ff @(negedge tck or posedge trst) begin
        if (trst) begin
            tdo_oe <= 1'b0;
        end else begin
            tdo_oe <= (state == S_SH_DR) || (state == S_SH_IR);
        end
    end
`endif

endmodule
